// File: rtl/run_length_packer.sv
`default_nettype none
// ============================================================================
// Module      : run_length_packer
// Description : Measures runs of consecutive '1' tokens on a serial stream and
//               queues each completed run length in a small show-ahead FIFO.
//               Runs longer than MAX_RUN saturate. Sticky flags report
//               saturation, words lost to a full FIFO and (optionally)
//               odd-length runs.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   MAX_RUN    largest countable run length (2**LEN_W must exceed it)
//   LEN_W      width of a run-length word
//   DEPTH      FIFO entries, power of two, >= 2
// Ports
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous active-low reset
//   a           in   1      serial token stream, '1' = token
//   len_valid   out  1      FIFO head holds a completed run length
//   len_data    out  LEN_W  run length at FIFO head (0 while empty)
//   len_ready   in   1      consumer takes the head word when len_valid=1
//   sat_err     out  1      sticky: a run exceeded MAX_RUN
//   drop_err    out  1      sticky: a completed run was lost (FIFO full)
//   parity_err  out  1      sticky: a completed run had odd length
// Build option
//   RUN_PARITY_CHECK_EN  when defined, every pushed length (accepted or
//                        dropped) is parity checked; an odd length sets
//                        parity_err one cycle after the push. When
//                        undefined, parity_err is tied low.
// ============================================================================
module run_length_packer #(
  parameter int MAX_RUN = 400,
  parameter int LEN_W   = 9,
  parameter int DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  output logic             len_valid,
  output logic [LEN_W-1:0] len_data,
  input  logic             len_ready,
  output logic             sat_err,
  output logic             drop_err,
  output logic             parity_err
);

  localparam int                 PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LEN_W-1:0]   C_MAX_RUN  = LEN_W'(MAX_RUN);
  localparam logic [LEN_W-1:0]   C_LEN_ONE  = LEN_W'(1);
  localparam logic [PTR_W-1:0]   C_PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]     C_CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]     C_DEPTH    = (PTR_W+1)'(DEPTH);

  // --------------------------------------------------------------------------
  // Run counter
  // --------------------------------------------------------------------------
  logic [LEN_W-1:0] r_cnt;
  logic             r_sat_err;
  logic             w_push;
  logic [LEN_W-1:0] w_push_data;
  logic             w_at_max;

  // A run ends on the first '0' that follows at least one '1'; the value
  // pushed is the count accumulated so far (already clamped at MAX_RUN).
  assign w_push      = ~a & (r_cnt != '0);
  assign w_push_data = r_cnt;
  assign w_at_max    = (r_cnt == C_MAX_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_sat_err <= 1'b0;
    end else begin
      if (a) begin
        if (w_at_max) begin
          r_sat_err <= 1'b1;
        end else begin
          r_cnt <= r_cnt + C_LEN_ONE;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output FIFO (show-ahead, occupancy counter separates full from empty)
  // --------------------------------------------------------------------------
  logic [LEN_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_drop_err;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_wr_en;
  logic             w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == C_DEPTH);
  assign w_pop   = ~w_empty & len_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted when the consumer is draining.
  assign w_wr_en = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;

  // Storage is not reset: entries are only visible once written.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop_err <= 1'b0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_drop_err <= 1'b1;
      end
    end
  end

  assign len_valid = ~w_empty;
  // Gated so the output reads 0 whenever the FIFO is empty, including reset.
  assign len_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign sat_err   = r_sat_err;
  assign drop_err  = r_drop_err;

  // --------------------------------------------------------------------------
  // Optional odd-length detection
  // --------------------------------------------------------------------------
`ifdef RUN_PARITY_CHECK_EN
  logic r_parity_err;

  // Dropped words are checked too, so this keys off the push, not the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity_err <= 1'b0;
    end else if (w_push & w_push_data[0]) begin
      r_parity_err <= 1'b1;
    end
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_run_length_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_run_length_packer
// Description : Self-checking bench for run_length_packer. A queue-based
//               reference model tracks run lengths and FIFO occupancy; every
//               accepted word is pushed into a scoreboard that a separate
//               monitor drains whenever the DUT hands a word over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_run_length_packer;

  localparam int MAX_RUN = 400;
  localparam int LEN_W   = 9;
  localparam int DEPTH   = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             a;
  logic             len_valid;
  logic [LEN_W-1:0] len_data;
  logic             len_ready;
  logic             sat_err;
  logic             drop_err;
  logic             parity_err;

  always #5 clk = ~clk;

  run_length_packer #(
    .MAX_RUN (MAX_RUN),
    .LEN_W   (LEN_W),
    .DEPTH   (DEPTH)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .len_valid  (len_valid),
    .len_data   (len_data),
    .len_ready  (len_ready),
    .sat_err    (sat_err),
    .drop_err   (drop_err),
    .parity_err (parity_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int ones;          // ones seen in the current run (unclamped)
  int mq[$];         // words the FIFO should hold
  int exp_q[$];      // scoreboard: accepted words in delivery order
  bit m_sat, m_drop, m_par, m_par_pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    ones = 0;
    mq.delete();
    exp_q.delete();
    m_sat = 0; m_drop = 0; m_par = 0; m_par_pend = 0;
  endtask

  // Apply one cycle of stimulus, advance the model across the coming edge,
  // and return 1 time unit after that edge.
  task automatic drive(input bit av, input bit rv);
    bit pop, push;
    int pl;
    a = av;
    len_ready = rv;
    m_par = m_par | m_par_pend;
    m_par_pend = 0;
    pop  = (mq.size() > 0) && rv;
    push = 0;
    pl   = 0;
    if (av) begin
      ones++;
      if (ones > MAX_RUN) m_sat = 1;
    end else if (ones > 0) begin
      push = 1;
      pl   = (ones > MAX_RUN) ? MAX_RUN : ones;
      ones = 0;
    end
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < DEPTH) begin
        mq.push_back(pl);
        exp_q.push_back(pl);
      end else begin
        m_drop = 1;
      end
`ifdef RUN_PARITY_CHECK_EN
      if ((pl % 2) == 1) m_par_pend = 1;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_run(input int n, input bit rv);
    for (int i = 0; i < n; i++) drive(1'b1, rv);
    drive(1'b0, rv);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a = 1'b0;
    len_ready = 1'b0;
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_sat"},    sat_err,    m_sat);
    chk({tag, "_drop"},   drop_err,   m_drop);
    chk({tag, "_parity"}, parity_err, m_par);
  endtask

  task automatic drain(input string tag);
    repeat (DEPTH + 4) drive(1'b0, 1'b1);
    chk({tag, "_valid_after_drain"}, len_valid, 1'b0);
    chk({tag, "_words_missing"}, exp_q.size(), 0);
  endtask

  // Scoreboard monitor: a handover happens at the next edge whenever valid
  // and ready are both high at the falling edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && len_valid === 1'b1 && len_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected_word actual=%0d required=none", len_data);
      end else begin
        chk("sb_data", len_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    bit s033 [10];
    int rl, gap;
    bit rv;

    rst_n = 1'b0;
    a = 1'b0;
    len_ready = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    chk("reset_valid", len_valid, 1'b0);
    chk("reset_data",  len_data,  0);
    chk_flags("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Two runs, consumer always ready; each word visible the cycle after
    // its terminating zero.
    s033 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive(s033[i], 1'b1);
      if (i == 3) begin
        chk("basic_valid_run2", len_valid, 1'b1);
        chk("basic_data_run2",  len_data,  2);
      end
      if (i == 9) begin
        chk("basic_valid_run4", len_valid, 1'b1);
        chk("basic_data_run4",  len_data,  4);
      end
    end
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    chk_flags("basic");
    chk("basic_flags_clear", {sat_err, drop_err, parity_err}, 3'b000);

    // Overfill while stalled: fifth word is dropped.
    do_reset();
    send_run(2, 1'b0);
    send_run(4, 1'b0);
    send_run(6, 1'b0);
    send_run(8, 1'b0);
    chk("fill_drop_before", drop_err, 1'b0);
    send_run(10, 1'b0);
    chk("fill_drop_after", drop_err, 1'b1);
    chk("fill_head", len_data, 2);
    drain("fill");
    chk_flags("fill");

    // Full FIFO with push and pop on the same edge: word accepted.
    do_reset();
    send_run(1, 1'b0);
    send_run(3, 1'b0);
    send_run(5, 1'b0);
    send_run(7, 1'b0);
    for (int i = 0; i < 9; i++) drive(1'b1, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    chk("fullpush_drop", drop_err, 1'b0);
    chk("fullpush_valid", len_valid, 1'b1);
    chk("fullpush_head", len_data, 3);
    drain("fullpush");
    chk_flags("fullpush");

    // Saturation.
    do_reset();
    for (int i = 0; i < MAX_RUN; i++) drive(1'b1, 1'b1);
    chk("sat_not_yet", sat_err, 1'b0);
    drive(1'b1, 1'b1);
    chk("sat_set", sat_err, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    chk("sat_valid", len_valid, 1'b1);
    chk("sat_data",  len_data,  MAX_RUN);
    drive(1'b0, 1'b1);
    chk_flags("sat");

    // Asynchronous reset mid-run; input held high through reset.
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("areset_valid", len_valid, 1'b0);
    chk("areset_data",  len_data,  0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    a = 1'b0;
    send_run(3, 1'b0);
    chk("areset_valid_after", len_valid, 1'b1);
    chk("areset_data_after",  len_data,  3);
    drive(1'b0, 1'b1);
    chk_flags("areset");

    // Odd run length.
    do_reset();
    drive(1'b0, 1'b0);
    send_run(3, 1'b0);
    chk("odd_data", len_data, 3);
    drive(1'b0, 1'b0);
`ifdef RUN_PARITY_CHECK_EN
    chk("odd_parity", parity_err, 1'b1);
`else
    chk("odd_parity", parity_err, 1'b0);
`endif
    drain("odd");
    chk_flags("odd_sticky");

    // Randomized traffic, including occasional saturating runs.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rl  = ($urandom_range(0, 39) == 0) ? int'($urandom_range(395, 410))
                                         : int'($urandom_range(1, 9));
      gap = $urandom_range(1, 3);
      for (int i = 0; i < rl + gap; i++) begin
        rv = ($urandom_range(0, 9) < 5);
        drive(i < rl, rv);
      end
      if ((n % 50) == 49) chk_flags("rand_mid");
    end
    drain("rand");
    chk_flags("rand_end");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
